// File: rtl/unified_memory_pkg.sv
// Shared constants and helpers for the unified I/D memory: funct3 codes,
// lane geometry, fault decode, byte enables and load extension.
package unified_memory_pkg;

    localparam int N      = 32;
    localparam int LANES  = 4;
    localparam int BE_W   = 4;
    localparam int LANE_W = 2;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Illegal funct3 or an address not aligned to the access size.
    function automatic logic access_fault(input logic [2:0] f3, input logic [LANE_W-1:0] lane);
        logic flt;
        case (f3)
            F3_B, F3_BU: flt = 1'b0;
            F3_H, F3_HU: flt = lane[0];
            F3_W:        flt = (lane != 2'b00);
            default:     flt = 1'b1;
        endcase
        return flt;
    endfunction

    function automatic logic [BE_W-1:0] store_be(input logic [1:0] size, input logic [LANE_W-1:0] lane);
        logic [BE_W-1:0] be;
        case (size)
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate low-aligned store data across lanes so any enabled lane sees it.
    function automatic logic [N-1:0] store_align(input logic [1:0] size, input logic [N-1:0] wdata);
        logic [N-1:0] al;
        case (size)
            2'b00:   al = {4{wdata[7:0]}};
            2'b01:   al = {2{wdata[15:0]}};
            default: al = wdata;
        endcase
        return al;
    endfunction

    function automatic logic [N-1:0] load_extend(input logic [2:0] f3, input logic [LANE_W-1:0] lane,
                                                 input logic [N-1:0] word);
        logic [7:0]   b;
        logic [15:0]  h;
        logic [N-1:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_BU:   r = {24'h000000, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_HU:   r = {16'h0000, h};
            F3_W:    r = word;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/unified_memory_if.sv
// Fetch (I) and load/store (D) port bundle between core and unified memory.
interface unified_memory_if;
    import unified_memory_pkg::*;

    logic         i_req;
    logic [N-1:0] i_addr;
    logic [N-1:0] i_rdata;
    logic         i_valid;
    logic         d_req;
    logic         d_we;
    logic [2:0]   d_funct3;
    logic [N-1:0] d_addr;
    logic [N-1:0] d_wdata;
    logic [N-1:0] d_rdata;
    logic         d_valid;
    logic         d_fault;

    modport master (
        output i_req, i_addr, d_req, d_we, d_funct3, d_addr, d_wdata,
        input  i_rdata, i_valid, d_rdata, d_valid, d_fault
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_funct3, d_addr, d_wdata,
        output i_rdata, i_valid, d_rdata, d_valid, d_fault
    );

endinterface

// File: rtl/unified_memory_ram_bank.sv
// Four byte-lane arrays: one byte-enabled write port, two registered read ports
// (A = fetch, B = data). Reads return the pre-write contents on a same-word write.
module unified_memory_ram_bank
    import unified_memory_pkg::*;
#(
    parameter int LENGTH = 512,
    parameter int WIDTH  = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] waddr,
    input  logic [BE_W-1:0]  be,
    input  logic [N-1:0]     wdata,
    input  logic             a_en,
    input  logic [WIDTH-1:0] a_addr,
    output logic [N-1:0]     a_q,
    input  logic             b_en,
    input  logic [WIDTH-1:0] b_addr,
    output logic [N-1:0]     b_q
);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [7:0] mem_r [LENGTH];
        logic [7:0] a_byte_r;
        logic [7:0] b_byte_r;

        // Byte-lane write.
        always_ff @(posedge clk) begin
            if (we && be[l]) begin
                mem_r[waddr] <= wdata[8*l +: 8];
            end
        end

        // Registered read ports, cleared by reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                a_byte_r <= 8'h00;
                b_byte_r <= 8'h00;
            end else begin
                if (a_en) begin
                    a_byte_r <= mem_r[a_addr];
                end
                if (b_en) begin
                    b_byte_r <= mem_r[b_addr];
                end
            end
        end

        assign a_q[8*l +: 8] = a_byte_r;
        assign b_q[8*l +: 8] = b_byte_r;
    end

endmodule

// File: rtl/unified_memory.sv
// Unified dual-port memory top: D-port decode/fault/extension, I-port fetch,
// valid pipeline. Optional same-cycle store-to-fetch forwarding under MEM_FWD_EN.
module unified_memory
    import unified_memory_pkg::*;
#(
    parameter int LENGTH = 512,
    parameter int WIDTH  = 9
) (
    input  logic             clk,
    input  logic             rst,
    unified_memory_if.slave  bus
);

    logic [WIDTH-1:0]  i_idx_s;
    logic [WIDTH-1:0]  d_idx_s;
    logic [LANE_W-1:0] d_lane_s;
    logic              d_flt_s;
    logic              d_wr_s;
    logic              d_rd_s;
    logic [BE_W-1:0]   d_be_s;
    logic [N-1:0]      d_wdata_al_s;
    logic [N-1:0]      i_q_s;
    logic [N-1:0]      d_q_s;
    logic [N-1:0]      i_word_s;
    logic [N-1:0]      i_rdata_s;
    logic [N-1:0]      d_rdata_s;
    logic              unused_addr_s;

    logic              i_valid_r;
    logic              d_valid_r;
    logic              d_fault_r;
    logic              d_load_r;
    logic [2:0]        d_f3_r;
    logic [LANE_W-1:0] d_lane_r;

    assign unused_addr_s = ^{bus.i_addr[N-1:WIDTH+2], bus.i_addr[1:0], bus.d_addr[N-1:WIDTH+2]};

    // D-port decode: word index, lane, fault and store lane enables.
    always_comb begin
        i_idx_s      = bus.i_addr[WIDTH+1:2];
        d_idx_s      = bus.d_addr[WIDTH+1:2];
        d_lane_s     = bus.d_addr[1:0];
        d_flt_s      = access_fault(bus.d_funct3, d_lane_s);
        d_wr_s       = bus.d_req & bus.d_we & ~d_flt_s & ~rst;
        d_rd_s       = bus.d_req & ~bus.d_we & ~d_flt_s;
        d_be_s       = store_be(bus.d_funct3[1:0], d_lane_s);
        d_wdata_al_s = store_align(bus.d_funct3[1:0], bus.d_wdata);
    end

    unified_memory_ram_bank #(
        .LENGTH (LENGTH),
        .WIDTH  (WIDTH)
    ) u_bank (
        .clk    (clk),
        .rst    (rst),
        .we     (d_wr_s),
        .waddr  (d_idx_s),
        .be     (d_be_s),
        .wdata  (d_wdata_al_s),
        .a_en   (bus.i_req),
        .a_addr (i_idx_s),
        .a_q    (i_q_s),
        .b_en   (d_rd_s),
        .b_addr (d_idx_s),
        .b_q    (d_q_s)
    );

    // Response valid pipeline and load context, one cycle behind the request.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_valid_r <= 1'b0;
            d_valid_r <= 1'b0;
            d_fault_r <= 1'b0;
            d_load_r  <= 1'b0;
            d_f3_r    <= 3'b000;
            d_lane_r  <= 2'b00;
        end else begin
            i_valid_r <= bus.i_req;
            d_valid_r <= bus.d_req;
            d_fault_r <= bus.d_req & d_flt_s;
            d_load_r  <= d_rd_s;
            d_f3_r    <= bus.d_funct3;
            d_lane_r  <= d_lane_s;
        end
    end

`ifdef MEM_FWD_EN
    logic            fwd_hit_r;
    logic [BE_W-1:0] fwd_be_r;
    logic [N-1:0]    fwd_data_r;

    // Capture a same-cycle store to the word being fetched (faulted stores never set d_wr_s).
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_hit_r  <= 1'b0;
            fwd_be_r   <= 4'b0000;
            fwd_data_r <= 32'h0000_0000;
        end else begin
            fwd_hit_r  <= bus.i_req & d_wr_s & (i_idx_s == d_idx_s);
            fwd_be_r   <= d_be_s;
            fwd_data_r <= d_wdata_al_s;
        end
    end

    // Merge forwarded store lanes over the read-first fetch word.
    always_comb begin
        i_word_s = i_q_s;
        for (int l = 0; l < LANES; l++) begin
            if (fwd_hit_r && fwd_be_r[l]) begin
                i_word_s[8*l +: 8] = fwd_data_r[8*l +: 8];
            end else begin
                i_word_s[8*l +: 8] = i_q_s[8*l +: 8];
            end
        end
    end
`else
    assign i_word_s = i_q_s;
`endif

    // Output data gating: zero unless a valid fetch / non-faulting load responds.
    always_comb begin
        if (i_valid_r) begin
            i_rdata_s = i_word_s;
        end else begin
            i_rdata_s = 32'h0000_0000;
        end
        if (d_valid_r && d_load_r) begin
            d_rdata_s = load_extend(d_f3_r, d_lane_r, d_q_s);
        end else begin
            d_rdata_s = 32'h0000_0000;
        end
    end

    assign bus.i_rdata = i_rdata_s;
    assign bus.i_valid = i_valid_r;
    assign bus.d_rdata = d_rdata_s;
    assign bus.d_valid = d_valid_r;
    assign bus.d_fault = d_fault_r;

endmodule
